// File: rtl/vga_pixel_fifo_if.sv
// Source-side pixel stream into vga_pixel_fifo: valid/ready handshake with an SOF tag.
interface vga_pixel_fifo_if #(
  parameter int unsigned DATA_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;

  modport master (output in_valid, in_data, in_sof, input in_ready);
  modport slave  (input in_valid, in_data, in_sof, output in_ready);
endinterface

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO feeding the VGA timing generator; resynchronises on SOF after underflow/misalign.
// Optional error counter output err_cnt is enabled by defining VGA_PIXEL_FIFO_STATS_EN.
module vga_pixel_fifo #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned HDISP  = 640,
  parameter int unsigned VDISP  = 480
) (
  input  logic                     clk,
  input  logic                     nrst,
  vga_pixel_fifo_if.slave          src,
  input  logic                     pix_frame_start,
  input  logic                     pix_req,
  output logic [DATA_W-1:0]        pix_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_sticky,
  input  logic                     err_clr
`ifdef VGA_PIXEL_FIFO_STATS_EN
  ,
  output logic [15:0]              err_cnt
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned FRAME = HDISP * VDISP;
  localparam int unsigned CW    = $clog2(FRAME + 1);

  typedef enum logic [1:0] {WAIT_SOF, ARMED, RUN} state_t;

  state_t          state, state_next;
  logic [DATA_W:0] mem [DEPTH];
  logic [AW:0]     wptr, rptr, wptr_next, rptr_next, level_next;
  logic [CW-1:0]   pixcnt, cnt_eff;
  logic [DATA_W:0] head;
  logic            in_ready_q, ready_next;
  logic            accept, empty, wr_en, pop, flush, err_evt;

  assign src.in_ready = in_ready_q;
  assign accept       = src.in_valid && in_ready_q;
  assign level        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign head         = mem[rptr[AW-1:0]];
  // A frame_start in the same cycle as a request restarts the count first.
  assign cnt_eff      = pix_frame_start ? '0 : pixcnt;

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    err_evt    = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (accept && src.in_sof) begin
          wr_en      = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        wr_en = accept;
        if (pix_frame_start) state_next = RUN;
      end
      RUN: begin
        if (pix_req) begin
          if (empty)                                 err_evt = 1'b1;
          else if (head[DATA_W] != (cnt_eff == '0))  err_evt = 1'b1;
          else if (cnt_eff != CW'(FRAME))            pop     = 1'b1;
        end
        flush = err_evt;
        wr_en = accept && !err_evt;
        if (err_evt) state_next = WAIT_SOF;
      end
      default: state_next = WAIT_SOF;
    endcase

    wptr_next  = wr_en ? wptr + (AW+1)'(1) : wptr;
    rptr_next  = flush ? wptr : (pop ? rptr + (AW+1)'(1) : rptr);
    level_next = wptr_next - rptr_next;
    // Registered ready looks ahead at next-cycle occupancy so it never overstates space.
    ready_next = (state_next == WAIT_SOF) || !level_next[AW];
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= WAIT_SOF;
      wptr       <= '0;
      rptr       <= '0;
      pixcnt     <= '0;
      pix_data   <= '0;
      in_ready_q <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_next;
      wptr       <= wptr_next;
      rptr       <= rptr_next;
      in_ready_q <= ready_next;
      if (pop)                  pixcnt <= cnt_eff + CW'(1);
      else if (pix_frame_start) pixcnt <= '0;
      if (pix_req)              pix_data <= pop ? head[DATA_W-1:0] : '0;
      if (err_evt)              err_sticky <= 1'b1;
      else if (err_clr)         err_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= {src.in_sof, src.in_data};
  end

`ifdef VGA_PIXEL_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_cnt <= '0;
    end else if (err_evt) begin
      if (err_clr)               err_cnt <= 16'd1;
      else if (err_cnt != '1)    err_cnt <= err_cnt + 16'd1;
    end else if (err_clr) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule
